// File: rtl/cve2_ex_unit_sequencer.sv
// cve2_ex_unit_sequencer: issues operations to NUM_UNITS execution units and
// retires their results in issue order through one writeback port.
// Each unit gets a one-entry holding register so that early results from a
// later op can wait for the in-order head. On a flush, results still owed by
// the units are counted and dropped as they arrive.
// Optional watchdog: define CVE2_EX_SEQ_TIMEOUT_EN to build it; otherwise
// timeout_o is tied low.

// Per-unit slot: result holding register plus outstanding/discard counters.
module cve2_ex_seq_slot #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              issue_i,
  input  logic              pop_i,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [4:0]        status_i,
  output logic              rready_o,
  output logic              hold_vld_o,
  output logic [DATA_W-1:0] hold_res_o,
  output logic [4:0]        hold_st_o,
  output logic              disc_nz_o
);
  localparam int CW = $clog2(DEPTH + 1);
  // One extra bit: new ops may be issued while an earlier flush is still
  // being drained, so the discard count can exceed DEPTH after a second flush.
  localparam int DW = CW + 1;

  logic [CW-1:0]     outst_q;
  logic [DW-1:0]     disc_q;
  logic              hold_vld_q;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        st_q;
  logic              acc, drop, cap;

  assign disc_nz_o  = (disc_q != '0);
  assign rready_o   = !hold_vld_q | disc_nz_o;
  assign acc        = rvalid_i & rready_o;
  assign drop       = acc & disc_nz_o;
  assign cap        = acc & !disc_nz_o;
  assign hold_vld_o = hold_vld_q;
  assign hold_res_o = res_q;
  assign hold_st_o  = st_q;

  // Holding register and counters; a flush moves the still-owed count into discard.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_q    <= '0;
      disc_q     <= '0;
      hold_vld_q <= 1'b0;
      res_q      <= '0;
      st_q       <= '0;
    end else if (flush_i) begin
      outst_q    <= '0;
      disc_q     <= disc_q - DW'(drop) + DW'(outst_q) - DW'(cap);
      hold_vld_q <= 1'b0;
    end else begin
      outst_q <= outst_q + CW'(issue_i) - CW'(cap);
      disc_q  <= disc_q - DW'(drop);
      if (cap) begin
        hold_vld_q <= 1'b1;
        res_q      <= result_i;
        st_q       <= status_i;
      end else if (pop_i) begin
        hold_vld_q <= 1'b0;
      end
    end
  end
endmodule

module cve2_ex_unit_sequencer #(
  parameter int NUM_UNITS      = 4,
  parameter int DEPTH          = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  logic [$clog2(NUM_UNITS)-1:0]        issue_unit_i,
  output logic [NUM_UNITS-1:0]                unit_valid_o,
  input  logic [NUM_UNITS-1:0]                unit_ready_i,
  input  logic [NUM_UNITS-1:0]                unit_rvalid_i,
  output logic [NUM_UNITS-1:0]                unit_rready_o,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]    unit_result_i,
  input  logic [NUM_UNITS-1:0][4:0]           unit_status_i,
  output logic                                wb_valid_o,
  input  logic                                wb_ready_i,
  output logic [DATA_W-1:0]                   wb_result_o,
  output logic [4:0]                          wb_status_o,
  output logic [$clog2(NUM_UNITS)-1:0]        wb_unit_o,
  input  logic                                flush_i,
  output logic                                busy_o,
  output logic                                timeout_o
);
  localparam int UW = $clog2(NUM_UNITS);
  localparam int PW = $clog2(DEPTH);

  logic [UW-1:0]                 fifo_q [DEPTH];
  logic [PW:0]                   wr_ptr_q, rd_ptr_q;
  logic                          empty, full, in_range, pop;
  logic [UW-1:0]                 head;
  logic [NUM_UNITS-1:0]          hold_vld, disc_nz, pop_vec;
  logic [NUM_UNITS-1:0][DATA_W-1:0] hold_res;
  logic [NUM_UNITS-1:0][4:0]     hold_st;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign in_range = ({1'b0, issue_unit_i} < (UW+1)'(NUM_UNITS));
  assign head     = fifo_q[rd_ptr_q[PW-1:0]];

  // Full blocks issue regardless of a same-cycle pop, keeping ready off the wb path.
  assign issue_ready_o = issue_valid_i & !full & !flush_i & in_range
                       && unit_ready_i[issue_unit_i];

  // Start strobe to the addressed unit, only on an accepted issue.
  always_comb begin
    unit_valid_o = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      unit_valid_o[u] = issue_ready_o & (issue_unit_i == UW'(u));
  end

  assign wb_valid_o  = !empty & hold_vld[head] & !flush_i;
  assign wb_result_o = hold_res[head];
  assign wb_status_o = hold_st[head];
  assign wb_unit_o   = head;
  assign pop         = wb_valid_o & wb_ready_i;
  assign busy_o      = !empty | (|disc_nz);

  // Pop strobe routed to the head unit's holding register.
  always_comb begin
    pop_vec = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      pop_vec[u] = pop & (head == UW'(u));
  end

  // In-order tag FIFO of unit indices.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (issue_ready_o) begin
        fifo_q[wr_ptr_q[PW-1:0]] <= issue_unit_i;
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot
    cve2_ex_seq_slot #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .issue_i    (unit_valid_o[u]),
      .pop_i      (pop_vec[u]),
      .rvalid_i   (unit_rvalid_i[u]),
      .result_i   (unit_result_i[u]),
      .status_i   (unit_status_i[u]),
      .rready_o   (unit_rready_o[u]),
      .hold_vld_o (hold_vld[u]),
      .hold_res_o (hold_res[u]),
      .hold_st_o  (hold_st[u]),
      .disc_nz_o  (disc_nz[u])
    );
  end

`ifdef CVE2_EX_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          to_q;

  // Watchdog: count stalled cycles with work pending; sticky flag until flush.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else if (flush_i) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else if (pop) begin
      to_cnt_q <= '0;
    end else if (!empty) begin
      if (to_cnt_q != TW'(TIMEOUT_CYCLES)) to_cnt_q <= to_cnt_q + TW'(1);
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) to_q <= 1'b1;
    end
  end
  assign timeout_o = to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_o = 1'b0;
`endif
endmodule

// File: doc/cve2_ex_unit_sequencer.md
CVE2_EX_UNIT_SEQUENCER -- requirements
Module: cve2_ex_unit_sequencer

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, the number of attached execution units (2..8).
REQ-002 SHALL have parameter DEPTH, default 4, the maximum number of in-flight operations (power of two, 2..16).
REQ-003 SHALL have parameter DATA_W, default 32, the result width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, the watchdog limit (used only when the macro in REQ-033 is defined).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port issue_valid_i, input, 1 bit: an issue request is present.
REQ-008 SHALL have port issue_ready_o, output, 1 bit: the issue request is accepted.
REQ-009 SHALL have port issue_unit_i, input, $clog2(NUM_UNITS) bits: the target unit index.
REQ-010 SHALL have port unit_valid_o, output, NUM_UNITS bits: one-hot start strobe to each unit.
REQ-011 SHALL have port unit_ready_i, input, NUM_UNITS bits: each unit can accept an operation.
REQ-012 SHALL have port unit_rvalid_i, input, NUM_UNITS bits: each unit is presenting a result.
REQ-013 SHALL have port unit_rready_o, output, NUM_UNITS bits: the sequencer accepts that unit's result.
REQ-014 SHALL have port unit_result_i, input, NUM_UNITS x DATA_W bits: the per-unit results.
REQ-015 SHALL have port unit_status_i, input, NUM_UNITS x 5 bits: the per-unit exception flags.
REQ-016 SHALL have port wb_valid_o, output, 1 bit: an in-order result is available for writeback.
REQ-017 SHALL have port wb_ready_i, input, 1 bit: writeback accepts the result.
REQ-018 SHALL have port wb_result_o, output, DATA_W bits: the writeback data.
REQ-019 SHALL have port wb_status_o, output, 5 bits: the writeback flags.
REQ-020 SHALL have port wb_unit_o, output, $clog2(NUM_UNITS) bits: the unit that produced the result.
REQ-021 SHALL have port flush_i, input, 1 bit: discard all in-flight operations.
REQ-022 SHALL have port busy_o, output, 1 bit: operations are in flight or pending discard.
REQ-023 SHALL have port timeout_o, output, 1 bit: the watchdog has fired (sticky).

Function
REQ-024 SHALL hold an in-order tag FIFO of DEPTH unit indices; an issue handshake pushes issue_unit_i; a writeback handshake pops the head.
REQ-025 SHALL drive issue_ready_o = issue_valid_i & !full & !flush_i & (issue_unit_i < NUM_UNITS) & unit_ready_i[issue_unit_i]; full SHALL block issue even if a pop occurs in the same cycle.
REQ-026 SHALL assert unit_valid_o[issue_unit_i] combinationally only in a cycle where the issue handshake occurs; an out-of-range index SHALL never be forwarded and SHALL stall.
REQ-027 SHALL give each unit a one-entry result holding register (result, status); unit_rready_o[u] SHALL be high when that register is empty or when unit u has a nonzero discard count.
REQ-028 SHALL assert wb_valid_o when the holding register of the FIFO head unit is full and flush_i is low; the minimum latency from unit_rvalid_i to wb_valid_o SHALL be 1 cycle.
REQ-029 SHALL clear the head holding register and pop the FIFO on wb_valid_o & wb_ready_i; a holding register freed in cycle N SHALL accept a new result in cycle N+1.
REQ-030 SHALL keep a per-unit outstanding counter (0..DEPTH); on flush_i, each unit's outstanding count SHALL be added to its discard counter, and the FIFO and holding registers SHALL be cleared; later results from that unit SHALL be accepted and dropped, decrementing the discard counter, until it reaches zero.
REQ-031 SHALL drive busy_o = (FIFO not empty) | (any discard counter nonzero).

Reset
REQ-032 SHALL, while rst_ni is low at a clk_i edge, empty the FIFO, clear the holding registers and all counters, and clear timeout_o; in the following cycle, wb_valid_o=0, busy_o=0, unit_valid_o=0 and unit_rready_o all-ones. A reset mid-operation SHALL abandon all in-flight operations without a discard phase.

Configuration
REQ-033 SHALL, with CVE2_EX_SEQ_TIMEOUT_EN defined, count cycles in which the FIFO is non-empty and no pop occurs; the counter SHALL reset on a pop or a flush; timeout_o SHALL set when the count reaches TIMEOUT_CYCLES and SHALL stay set until flush_i or reset. Without the macro, no counter SHALL be built and timeout_o SHALL be tied to 0.

Verification
REQ-034 SHALL cover: issue to unit 2, unit responds 3 cycles later with 0xDEADBEEF -> wb_valid_o 1 cycle after rvalid, wb_unit_o=2.
REQ-035 SHALL cover: issue unit 1 then unit 0; unit 0 responds first -> unit 0 result held, wb order 1 then 0.
REQ-036 SHALL cover: 4 issues with DEPTH=4 and wb_ready_i=0 -> issue_ready_o=0 on the 5th request, including a same-cycle pop.
REQ-037 SHALL cover: 2 ops outstanding on unit 3, flush, then 2 late results -> both dropped, busy_o falls after the second, no wb_valid_o.
REQ-038 SHALL cover: with the macro defined and TIMEOUT_CYCLES=8, one op never answered -> timeout_o rises after 8 stalled cycles and clears on flush.
